// File: rtl/roic_readout_scheduler.sv
// Round-robin ROIC readout scheduler: walks every channel for each line of a frame.
// Optional idle-timeout skip of a stalled channel is enabled with ROIC_SCHED_TIMEOUT_EN.
module roic_readout_scheduler #(
    parameter int NUM_ROIC    = 12,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                clk_100mhz,
    input  logic                rst_100mhz,
    input  logic                start,
    input  logic                abort,
    input  logic [15:0]         max_v_count,
    input  logic [15:0]         max_h_count,
    input  logic [NUM_ROIC-1:0] roic_valid,
    input  logic                tready,
    output logic [NUM_ROIC-1:0] data_read_req,
    output logic [3:0]          roic_sel,
    output logic                beat,
    output logic                tlast,
    output logic                frame_start,
    output logic                frame_done,
    output logic [15:0]         line_cnt,
    output logic                busy,
    output logic                err_timeout
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FSTART = 3'd1;
    localparam logic [2:0] ST_XFER   = 3'd2;
    localparam logic [2:0] ST_NEXT   = 3'd3;
    localparam logic [2:0] ST_FDONE  = 3'd4;

    localparam logic [3:0] LAST_SEL = 4'(NUM_ROIC - 1);

    if (NUM_ROIC < 1 || NUM_ROIC > 16 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("roic_readout_scheduler: NUM_ROIC must be 1..16 and TIMEOUT_CYC >= 1");
    end

    // Handshake: a word moves when the selected channel is valid and tready is high
    // during XFER; data_read_req is held steady on that channel across stalls.
    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [15:0] v_lat;
    logic [15:0] h_lat;
    logic [15:0] word_cnt;
    logic        sel_valid;
    logic        last_word;
    logic        seg_end;
    logic        last_chan;
    logic        last_line;
    logic        start_ok;
    logic        idle_hit;

    always_comb begin
        sel_valid = 1'b0;
        for (int i = 0; i < NUM_ROIC; i++) begin
            if (roic_sel == 4'(i)) begin
                sel_valid = roic_valid[i];
            end
        end
    end

    always_comb begin
        data_read_req = '0;
        if (state == ST_XFER) begin
            for (int i = 0; i < NUM_ROIC; i++) begin
                data_read_req[i] = (roic_sel == 4'(i));
            end
        end
    end

    assign beat        = (state == ST_XFER) && sel_valid && tready;
    assign last_word   = (word_cnt == h_lat - 16'd1);
    assign seg_end     = beat && last_word;
    assign last_chan   = (roic_sel == LAST_SEL);
    assign last_line   = (line_cnt == v_lat - 16'd1);
    assign tlast       = seg_end && last_chan;
    assign frame_start = (state == ST_FSTART);
    assign frame_done  = (state == ST_FDONE);
    assign busy        = (state != ST_IDLE);
    assign start_ok    = (state == ST_IDLE) && start && !abort &&
                         (max_v_count != 16'd0) && (max_h_count != 16'd0);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    state_nxt = ST_FSTART;
                end
            end
            ST_FSTART: state_nxt = ST_XFER;
            ST_XFER: begin
                if (seg_end || idle_hit) begin
                    state_nxt = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (last_chan && last_line) begin
                    state_nxt = ST_FDONE;
                end else begin
                    state_nxt = ST_XFER;
                end
            end
            ST_FDONE: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        if (abort) begin
            state_nxt = ST_IDLE;
        end
    end

    // On the final line the line index holds at max_v_count-1 so it never overshoots while busy.
    always_ff @(posedge clk_100mhz or posedge rst_100mhz) begin
        if (rst_100mhz) begin
            state    <= ST_IDLE;
            v_lat    <= '0;
            h_lat    <= '0;
            word_cnt <= '0;
            line_cnt <= '0;
            roic_sel <= '0;
        end else begin
            state <= state_nxt;
            if (abort) begin
                word_cnt <= '0;
                line_cnt <= '0;
                roic_sel <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_ok) begin
                            v_lat <= max_v_count;
                            h_lat <= max_h_count;
                        end
                    end
                    ST_FSTART: begin
                        word_cnt <= '0;
                        line_cnt <= '0;
                        roic_sel <= '0;
                    end
                    ST_XFER: begin
                        if (seg_end || idle_hit) begin
                            word_cnt <= '0;
                        end else if (beat) begin
                            word_cnt <= word_cnt + 16'd1;
                        end
                    end
                    ST_NEXT: begin
                        if (last_chan) begin
                            roic_sel <= '0;
                            if (!last_line) begin
                                line_cnt <= line_cnt + 16'd1;
                            end
                        end else begin
                            roic_sel <= roic_sel + 4'd1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

`ifdef ROIC_SCHED_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_CYC + 1);

    logic [IW-1:0] idle_cnt;

    // Fires on the XFER cycle that would bring the idle count up to TIMEOUT_CYC.
    assign idle_hit = (state == ST_XFER) && !beat && (idle_cnt == IW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_100mhz or posedge rst_100mhz) begin
        if (rst_100mhz) begin
            idle_cnt    <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (abort) begin
                idle_cnt <= '0;
            end else if (state != ST_XFER && state_nxt == ST_XFER) begin
                idle_cnt <= '0;
            end else if (state == ST_XFER) begin
                if (beat || idle_hit) begin
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end

            if (start_ok) begin
                err_timeout <= 1'b0;
            end else if (idle_hit && !abort) begin
                err_timeout <= 1'b1;
            end
        end
    end
`else
    assign idle_hit    = 1'b0;
    assign err_timeout = 1'b0;
`endif

endmodule
